// File: rtl/param_ram_pkg.sv
// param_ram_pkg: shared types and defaults for the param_ram block.
//   state_t      - controller state (CLEAR sweep / READY for traffic)
//   DEF_DATA_W   - default word width
//   DEF_ADDR_W   - default address width (DEPTH = 2**ADDR_W)
package param_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/param_ram_if.sv
// param_ram_if: request/response bundle for param_ram.
//   clear      - single-cycle request to zero the whole array
//   req_valid  - request present
//   req_ready  - block can accept a request this cycle
//   req_write  - 1 = write, 0 = read
//   req_adr    - target word address
//   req_data   - write data
//   rd_valid   - one-cycle pulse marking rd_data updated
//   rd_data    - registered read data
//   busy       - clear sweep in progress
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1. req_ready is combinational (depends on clear), so
// the master must not make req_valid depend on req_ready. Nothing happens
// to memory or read outputs for a cycle without acceptance.
interface param_ram_if
  import param_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output clear, req_valid, req_write, req_adr, req_data,
    input  req_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  clear, req_valid, req_write, req_adr, req_data,
    output req_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/param_ram_array.sv
// param_ram_array: storage for param_ram.
//   clock  - write and read-register clock
//   we     - write enable; mem[wadr] <= wdata
//   wadr   - write address
//   wdata  - write data
//   re     - read enable; rdata <= mem[radr]
//   radr   - read address
//   rdata  - registered read data, holds while re = 0
// No reset on the array or the read register.
module param_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] radr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wadr] <= wdata;
    end
    if (re) begin
      rdata <= mem[radr];
    end
  end

endmodule

// File: rtl/param_ram.sv
// param_ram: single-port RAM with a hardware clear sweep.
//   clock  - sole clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - param_ram_if.slave (clear, request, read response, busy)
//   state  - current controller state, for observation
// After reset or a clear request the controller sweeps the array, writing
// zero to one word per cycle (ascending), then serves one read or write per
// cycle. Reads return data one cycle after acceptance with rd_valid.
module param_ram
  import param_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  param_ram_if.slave      bus,
  output state_t          state
);

  localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_ptr;
  logic              accept;
  logic              rd_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;
  logic              rd_valid_q;
  logic              has_data;

  // Clear wins over any same-cycle request, so ready drops with clear.
  assign bus.req_ready = (state_q == READY) && !bus.clear;
  assign bus.busy      = (state_q == CLEAR);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_write;
  assign state         = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_ptr == LAST_ADR) state_d = READY;
      READY: if (bus.clear) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      // Pointer wraps to 0 naturally after the last word is zeroed.
      if (state_q == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // Write port is shared between the sweep and accepted writes; the two
  // never coincide because req_ready is 0 during the sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_wadr  = bus.req_adr;
    mem_wdata = bus.req_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_wadr  = clr_ptr;
      mem_wdata = '0;
    end else if (accept && bus.req_write) begin
      mem_we = 1'b1;
    end
  end

  param_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .wadr  (mem_wadr),
    .wdata (mem_wdata),
    .re    (rd_accept),
    .radr  (bus.req_adr),
    .rdata (mem_q)
  );

  // The array's read register has no reset; has_data forces rd_data to 0
  // from reset until the first read after it has loaded the register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      has_data   <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        has_data <= 1'b1;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = has_data ? mem_q : '0;

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed bench for param_ram (DATA_W=8, ADDR_W=3).
module tb_param_ram;
  import param_ram_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clock = 1'b0;
  logic   reset = 1'b0;
  state_t dut_state;

  always #5 clock = ~clock;

  param_ram_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  param_ram #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .state (dut_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Apply inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic c);
    @(negedge clock);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_adr   = a;
    bus.req_data  = d;
    bus.clear     = c;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  // Counts rising edges while busy stays high (bounded).
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      @(posedge clock);
      #1;
      cnt++;
    end
  endtask

  int cnt;

  initial begin
    bus.clear     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_adr   = '0;
    bus.req_data  = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",     64'(bus.busy), 64'd1);
    check("rst_ready",    64'(bus.req_ready), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data",  64'(bus.rd_data), 64'h00);
    check("rst_state",    64'(dut_state), 64'(CLEAR));

    // Initial sweep: 8 busy cycles, then ready
    @(negedge clock);
    reset = 1'b1;
    count_busy(cnt);
    check("init_sweep_len", 64'(cnt), 64'd8);
    check("init_ready",     64'(bus.req_ready), 64'd1);
    check("init_state",     64'(dut_state), 64'(READY));

    // All words read back as zero, rd_valid high for each read
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      check($sformatf("zero_rv_%0d", i), 64'(bus.rd_valid), 64'd1);
      check($sformatf("zero_rd_%0d", i), 64'(bus.rd_data), 64'h00);
    end
    idle();
    check("zero_rv_end", 64'(bus.rd_valid), 64'd0);

    // Write A5 to 3, read it next cycle
    drive(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
    check("wr_no_rv", 64'(bus.rd_valid), 64'd0);
    drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    check("raw_rv", 64'(bus.rd_valid), 64'd1);
    check("raw_rd", 64'(bus.rd_data), 64'hA5);
    // Valid low: no read happens, data holds
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("noacc_rv", 64'(bus.rd_valid), 64'd0);
    check("noacc_rd", 64'(bus.rd_data), 64'hA5);

    // Fill 0..7 with 10..17, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 3'(i), 8'h10 + 8'(i), 1'b0);
      exp_q.push_back(8'h10 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      drive(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      e = exp_q.pop_front();
      check($sformatf("b2b_rv_%0d", i), 64'(bus.rd_valid), 64'd1);
      check($sformatf("b2b_rd_%0d", i), 64'(bus.rd_data), 64'(e));
    end
    idle();

    // Clear with a same-cycle write of FF to 5: write is dropped
    @(negedge clock);
    bus.clear     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_adr   = 3'd5;
    bus.req_data  = 8'hFF;
    #1;
    check("clr_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clock);
    #1;
    bus.clear     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    check("clr_busy", 64'(bus.busy), 64'd1);
    count_busy(cnt);
    check("clr_sweep_len", 64'(cnt), 64'd8);
    check("clr_rd_hold",   64'(bus.rd_data), 64'h17);
    drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    check("clr_rd5_rv", 64'(bus.rd_valid), 64'd1);
    check("clr_rd5",    64'(bus.rd_data), 64'h00);
    drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    check("clr_rd3",    64'(bus.rd_data), 64'h00);

    // Reset in the middle of a sweep
    drive(1'b1, 1'b1, 3'd7, 8'h5A, 1'b0);
    drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    check("pre_rst_rd", 64'(bus.rd_data), 64'h5A);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    repeat (3) idle();
    check("mid_busy", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_busy",     64'(bus.busy), 64'd1);
    check("mrst_ready",    64'(bus.req_ready), 64'd0);
    check("mrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("mrst_rd_data",  64'(bus.rd_data), 64'h00);
    check("mrst_state",    64'(dut_state), 64'(CLEAR));
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      bus.clear = (cnt == 2 || cnt == 5);
      @(posedge clock);
      #1;
      cnt++;
    end
    bus.clear = 1'b0;
    check("mrst_sweep_len", 64'(cnt), 64'd8);
    drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    check("mrst_rd7_rv", 64'(bus.rd_valid), 64'd1);
    check("mrst_rd7",    64'(bus.rd_data), 64'h00);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (legal range 1..64).
REQ-002 Parameter ADDR_W, default 3, address width in bits; DEPTH = 2**ADDR_W words (derived, not overridable).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion is asynchronous, internal deassertion takes effect on the next rising clock edge.
REQ-005 clear  input  1  single-cycle request to zero the whole array.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read; sampled with req_valid.
REQ-009 req_adr  input  ADDR_W  target word address.
REQ-010 req_data  input  DATA_W  write data.
REQ-011 rd_valid  output  1  one-cycle pulse marking rd_data updated.
REQ-012 rd_data  output  DATA_W  registered read data.
REQ-013 busy  output  1  clear sweep in progress.

Function
REQ-014 FSM states CLEAR and READY only; the two states are mutually exclusive.
REQ-015 CLEAR: one word per cycle written to zero at clr_ptr, ascending 0..DEPTH-1; busy=1; req_ready=0.
REQ-016 CLEAR -> READY on the cycle that clr_ptr = DEPTH-1 is written; the sweep takes exactly DEPTH cycles; clr_ptr returns to 0.
REQ-017 READY: busy=0; req_ready = !clear (combinational).
REQ-018 READY with clear=1 -> CLEAR next edge; any same-cycle request is not accepted (clear has priority).
REQ-019 clear asserted while already in CLEAR is ignored; the sweep is not restarted.
REQ-020 Accept = req_valid && req_ready; no effect on memory, rd_data or rd_valid without accept.
REQ-021 Accepted write: mem[req_adr] <= req_data at the accepting edge; rd_valid stays 0.
REQ-022 Accepted read: rd_data <= mem[req_adr] and rd_valid <= 1 at the accepting edge (latency 1 cycle).
REQ-023 rd_valid is 1 for exactly one cycle per accepted read; back-to-back reads keep it high continuously.
REQ-024 rd_data holds its last value until the next accepted read, including across a clear sweep.
REQ-025 A read on the cycle after a write to the same address returns the new data; the single request port cannot produce a same-cycle read/write conflict.

Reset
REQ-026 While reset=0: state=CLEAR, clr_ptr=0, busy=1, req_ready=0, rd_valid=0, rd_data=0.
REQ-027 The memory array is not asynchronously reset; zeroing is done only by the CLEAR sweep that starts after reset deassertion.
REQ-028 Reset asserted mid-sweep or mid-traffic aborts all activity; the sweep restarts from address 0.

Structure
REQ-029 Package param_ram_pkg holds the state enumeration (CLEAR, READY) and the default DATA_W and ADDR_W constants.
REQ-030 Storage lives in sub-module param_ram_array: one synchronous write port and one registered read port, no reset; the FSM, clr_ptr and handshake live in param_ram.

Verification (DATA_W=8, ADDR_W=3)
REQ-031 Release reset -> busy=1 for 8 cycles, then req_ready=1; reads of addresses 0..7 all return 8'h00 with a one-cycle rd_valid each.
REQ-032 Write 8'hA5 to address 3, then read address 3 on the next cycle -> rd_data=8'hA5, rd_valid=1 one cycle after the read is accepted.
REQ-033 Write addresses 0..7 with 8'h10..8'h17, then issue 8 back-to-back reads -> rd_valid high for 8 cycles with data 8'h10..8'h17 in order.
REQ-034 clear together with a write of 8'hFF to address 5 -> write not accepted; busy=1 for 8 cycles; read of address 5 returns 8'h00; rd_data holds its previous value until that read.
REQ-035 Pulse reset at cycle 4 of a sweep -> outputs take reset values immediately; a full 8-cycle sweep follows; clear pulses during the sweep do not extend it.
